mips_mem_arbiter: RTL

Single-port memory arbiter for the pipelined MIPS core. It shares one synchronous single-port RAM (1024 × 32, registered address, 1-cycle read latency) between the instruction-fetch stage and the memory stage (lw/sw). Each cycle it grants at most one requester, steers address, write data and write enable to the RAM, and routes the read data back to its owner one cycle later. It also drives stall signals so the pipeline holds the losing stage.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mips_mem_arbiter_streak_ctr.sv | 44 ++++
 rtl/mips_mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared constants for the MIPS core memory path.
//   - ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   - OWN_NONE / OWN_IF / OWN_D : owner of the read response due next cycle
//   - OP_LW / OP_SW : load/store primary opcodes, shared with the pipeline decode
package mips_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] own_t;

  localparam own_t OWN_NONE = 2'd0;
  localparam own_t OWN_IF   = 2'd1;
  localparam own_t OWN_D    = 2'd2;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/mips_mem_arbiter_streak_ctr.sv
// arb_streak_ctr
//   Saturating counter tracking consecutive data grants while fetch waits.
//   Ports:
//     clk    in  clock
//     rst    in  asynchronous active-high reset
//     inc    in  count one more data grant (ignored once saturated)
//     clr    in  clear the count (has priority over inc)
//     at_max out count has reached MAX
module arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != MAX_V)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign at_max = (count_reg == MAX_V);

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//   Shares one single-port synchronous RAM (registered address, 1-cycle read
//   latency) between instruction fetch and the memory stage. Grants are
//   combinational and same-cycle; read data is routed back to its owner one
//   cycle after the grant. Data requests win conflicts (older instruction).
//
//   Build option: define ARB_FAIRNESS_EN to let fetch win after MAX_STREAK
//   consecutive data grants taken while fetch was waiting.
//
//   Ports:
//     arb_in_clk, arb_in_rst         clock, asynchronous active-high reset
//     if_req/if_addr/if_flush        fetch request, PC, branch-taken flush
//     if_gnt/if_rvalid/if_rdata      fetch grant and instruction response
//     d_req/d_we/d_addr/d_wdata      load/store request
//     d_gnt/d_rvalid/d_rdata         data grant and load response
//     mem_addr/mem_data/mem_wren     RAM drive
//     mem_q                          RAM read data (valid cycle after grant)
//     stall_if/stall_mem             hold the losing pipeline stage
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_STREAK = 4
) (
  input  logic              arb_in_clk,
  input  logic              arb_in_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              stall_if,
  output logic              stall_mem
);

  // Response FSM states coincide with the owner encoding.
  localparam logic [1:0] IDLE    = OWN_NONE;
  localparam logic [1:0] RESP_IF = OWN_IF;
  localparam logic [1:0] RESP_D  = OWN_D;

  logic [1:0]        rsp_own_reg,   rsp_own_next;
  logic              cancel_reg,    cancel_next;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [DATA_W-1:0] last_data_reg;
  logic              fetch_wins;

`ifdef ARB_FAIRNESS_EN
  logic streak_at_max;

  arb_streak_ctr #(
    .MAX (MAX_STREAK)
  ) u_streak (
    .clk    (arb_in_clk),
    .rst    (arb_in_rst),
    .inc    (d_gnt & if_req),
    .clr    (~if_req | if_gnt),
    .at_max (streak_at_max)
  );

  assign fetch_wins = streak_at_max;
`else
  logic unused_max_streak;
  assign unused_max_streak = (MAX_STREAK == 0);
  assign fetch_wins = 1'b0;
`endif

  // Grants are masked during reset so nothing reaches the RAM or stalls
  // the pipeline while the core is being reset.
  assign if_gnt    = ~arb_in_rst & if_req & (~d_req | fetch_wins);
  assign d_gnt     = ~arb_in_rst & d_req & ~if_gnt;
  assign stall_if  = ~arb_in_rst & if_req & ~if_gnt;
  assign stall_mem = ~arb_in_rst & d_req & ~d_gnt;

  // With no grant the RAM sees the last granted address/data so the bus
  // stays quiet.
  always_comb begin
    mem_addr = last_addr_reg;
    mem_data = last_data_reg;
    if (d_gnt) begin
      mem_addr = d_addr;
      mem_data = d_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  assign mem_wren = d_gnt & d_we;

  always_comb begin
    rsp_own_next = IDLE;
    if (if_gnt) begin
      rsp_own_next = RESP_IF;
    end else if (d_gnt && !d_we) begin
      rsp_own_next = RESP_D;
    end
  end

  // A fetch issued during a flush still occupies the RAM but its data is
  // for the wrong path, so remember to drop it.
  assign cancel_next = if_gnt & if_flush;

  always_ff @(posedge arb_in_clk or posedge arb_in_rst) begin
    if (arb_in_rst) begin
      rsp_own_reg   <= IDLE;
      cancel_reg    <= 1'b0;
      last_addr_reg <= '0;
      last_data_reg <= '0;
    end else begin
      rsp_own_reg   <= rsp_own_next;
      cancel_reg    <= cancel_next;
      last_addr_reg <= mem_addr;
      last_data_reg <= mem_data;
    end
  end

  // A flush arriving while the fetch response is on the bus also kills it.
  assign if_rvalid = (rsp_own_reg == RESP_IF) & ~cancel_reg & ~if_flush;
  assign d_rvalid  = (rsp_own_reg == RESP_D);
  assign if_rdata  = if_rvalid ? mem_q : '0;
  assign d_rdata   = d_rvalid  ? mem_q : '0;

endmodule
